// File: rtl/clk_lock_sequencer.sv
// clk_lock_sequencer
//   Watches the LOCKED outputs of the clock-generation CMTs/PLLs. Once every
//   lock has been stable for STABLE_CYCLES, it releases the per-domain resets
//   one at a time, STAGGER_CYCLES apart, in index order. A lock drop during
//   release or run re-asserts every domain reset and is logged for the host.
//
//   Optional feature (macro CLK_LOCK_TIMEOUT_EN): a lock-wait timeout that
//   pulses pll_rst for 8 cycles when locks have not been achieved within
//   TIMEOUT_CYCLES. Without the macro, pll_rst is constant 0.
//
// Ports
//   clk        IFCLK domain clock
//   reset      asynchronous, active-high reset
//   locked_in  raw LOCKED signals, asynchronous to clk
//   clr        single-cycle pulse, clears loss_cnt and loss_mask
//   rst_out    per-domain resets, active high
//   all_ready  high while all domain resets are released and locks are held
//   loss_cnt   saturating count of lock losses seen during release/run
//   loss_mask  sticky record of inputs that were low at a counted loss
//   pll_rst    lock-wait timeout pulse (optional feature)
module clk_lock_sequencer #(
   parameter int unsigned N_CMT          = 4,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned STAGGER_CYCLES = 16,
   parameter int unsigned SYNC_STAGES    = 2
`ifdef CLK_LOCK_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CMT-1:0] locked_in,
   input  logic             clr,
   output logic [N_CMT-1:0] rst_out,
   output logic             all_ready,
   output logic [7:0]       loss_cnt,
   output logic [N_CMT-1:0] loss_mask,
   output logic             pll_rst
);

   localparam int unsigned CNT_MAX = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IDX_W   = (N_CMT > 1) ? $clog2(N_CMT) : 1;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RELEASE,
      ST_RUN,
      ST_LOST
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [IDX_W-1:0]   idx, idx_d;
   logic [N_CMT-1:0]   rst_out_d;
   logic               all_ready_d;
   logic [7:0]         loss_cnt_d;
   logic [N_CMT-1:0]   loss_mask_d;
   logic [N_CMT-1:0]   sync_q [SYNC_STAGES];
   logic [N_CMT-1:0]   lock_s;
   logic [N_CMT-1:0]   lock_det_q;
   logic               all_locked_c;
   logic               timeout_c;

   // Per-bit synchronizer chain for the asynchronous lock inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= locked_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign lock_s       = sync_q[SYNC_STAGES-1];
   assign all_locked_c = &lock_s;

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_WAIT_LOCK;
         cnt        <= '0;
         idx        <= '0;
         rst_out    <= '1;
         all_ready  <= 1'b0;
         loss_cnt   <= '0;
         loss_mask  <= '0;
         lock_det_q <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         idx        <= idx_d;
         rst_out    <= rst_out_d;
         all_ready  <= all_ready_d;
         loss_cnt   <= loss_cnt_d;
         loss_mask  <= loss_mask_d;
         // LOST logs the lock pattern seen on the cycle that detected the drop
         lock_det_q <= lock_s;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      idx_d       = idx;
      rst_out_d   = rst_out;
      all_ready_d = all_ready;
      loss_cnt_d  = loss_cnt;
      loss_mask_d = loss_mask;

      if (clr) begin
         loss_cnt_d  = '0;
         loss_mask_d = '0;
      end

      case (state)
         ST_WAIT_LOCK: begin
            cnt_d       = '0;
            idx_d       = '0;
            rst_out_d   = '1;
            all_ready_d = 1'b0;
            if (all_locked_c) state_d = ST_STABLE;
         end
         ST_STABLE: begin
            if (!all_locked_c) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            // A drop takes priority over a release due on the same cycle
            if (!all_locked_c) begin
               state_d = ST_LOST;
            end else if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
               rst_out_d[idx] = 1'b0;
               cnt_d          = '0;
               idx_d          = idx + IDX_W'(1);
               if (idx == IDX_W'(N_CMT - 1)) state_d = ST_RUN;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!all_locked_c) state_d = ST_LOST;
            else               all_ready_d = 1'b1;
         end
         ST_LOST: begin
            // Loss update is applied on top of any clr, so the loss wins
            rst_out_d   = '1;
            all_ready_d = 1'b0;
            if (loss_cnt_d != 8'hFF) loss_cnt_d = loss_cnt_d + 8'd1;
            loss_mask_d = loss_mask_d | ~lock_det_q;
            state_d     = ST_WAIT_LOCK;
            cnt_d       = '0;
            idx_d       = '0;
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      if (timeout_c) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
      end
   end

`ifdef CLK_LOCK_TIMEOUT_EN
   logic [31:0] wait_cnt;
   logic [2:0]  pulse_cnt;
   logic        pll_rst_q;
   logic        waiting_c;

   assign waiting_c = (state == ST_WAIT_LOCK) || (state == ST_STABLE);
   assign timeout_c = waiting_c && !pll_rst_q && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign pll_rst   = pll_rst_q;

   // Lock-wait timer; held clear while the 8-cycle pll_rst pulse is active
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         pulse_cnt <= '0;
         pll_rst_q <= 1'b0;
      end else begin
         if (pll_rst_q) begin
            pulse_cnt <= pulse_cnt + 3'd1;
            if (pulse_cnt == 3'd7) pll_rst_q <= 1'b0;
         end
         if (timeout_c) begin
            pll_rst_q <= 1'b1;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
         end else if (pll_rst_q || !waiting_c) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 32'd1;
         end
      end
   end
`else
   assign timeout_c = 1'b0;
   assign pll_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_lock_sequencer.sv
// tb_clk_lock_sequencer
//   Self-checking bench for clk_lock_sequencer. A timestamp-based reference
//   model predicts every output from the time the synchronized locks became
//   all-high and from the time of any drop.
module tb_clk_lock_sequencer;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int G  = 4;
   localparam int SY = 2;
   localparam int READY_EL = S + G + 1 + (N - 1) * G + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic [3:0] locked_in;
   logic [3:0] rst_out;
   logic       all_ready;
   logic [7:0] loss_cnt;
   logic [3:0] loss_mask;
   logic       pll_rst;

   always #5 clk = ~clk;

   clk_lock_sequencer #(
      .N_CMT(N), .STABLE_CYCLES(S), .STAGGER_CYCLES(G), .SYNC_STAGES(SY)
`ifdef CLK_LOCK_TIMEOUT_EN
      , .TIMEOUT_CYCLES(65536)
`endif
   ) dut (
      .clk(clk), .reset(reset), .locked_in(locked_in), .clr(clr),
      .rst_out(rst_out), .all_ready(all_ready), .loss_cnt(loss_cnt),
      .loss_mask(loss_mask), .pll_rst(pll_rst)
   );

`ifdef CLK_LOCK_TIMEOUT_EN
   logic [3:0] to_lock = 4'h0;
   logic       to_clr  = 1'b0;
   logic [3:0] to_rst_out;
   logic       to_all_ready;
   logic [7:0] to_loss_cnt;
   logic [3:0] to_loss_mask;
   logic       to_pll_rst;

   clk_lock_sequencer #(
      .N_CMT(N), .STABLE_CYCLES(S), .STAGGER_CYCLES(G), .SYNC_STAGES(SY),
      .TIMEOUT_CYCLES(32)
   ) dut_to (
      .clk(clk), .reset(reset), .locked_in(to_lock), .clr(to_clr),
      .rst_out(to_rst_out), .all_ready(to_all_ready), .loss_cnt(to_loss_cnt),
      .loss_mask(to_loss_mask), .pll_rst(to_pll_rst)
   );
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int         edge_n;
   int         start;
   int         blocked_ok;
   int         loss_apply;
   logic [3:0] lost_seen;
   logic [3:0] m_ls;
   logic [3:0] dq[$];
   logic [3:0] exp_rst;
   logic       exp_ready;
   int         exp_cnt;
   logic [3:0] exp_mask;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s @edge %0d: observed %0h, expected %0h", tag, edge_n, obs, expv);
      end
   endtask

   task automatic model_reset();
      edge_n     = 0;
      start      = -1;
      blocked_ok = 0;
      loss_apply = -1;
      lost_seen  = '0;
      m_ls       = '0;
      dq.delete();
      for (int i = 0; i < SY - 1; i++) dq.push_back(4'h0);
      exp_rst    = 4'hF;
      exp_ready  = 1'b0;
      exp_cnt    = 0;
      exp_mask   = 4'h0;
   endtask

   // Predict outputs after this edge from the synchronized lock history
   task automatic model_edge();
      logic [3:0] seen;
      int el;
      edge_n++;
      seen = m_ls;
      if (loss_apply == edge_n) begin
         if (clr) begin
            exp_cnt  = 0;
            exp_mask = 4'h0;
         end
         exp_cnt    = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
         exp_mask   = exp_mask | ~lost_seen;
         exp_rst    = 4'hF;
         exp_ready  = 1'b0;
         loss_apply = -1;
      end else begin
         if (clr) begin
            exp_cnt  = 0;
            exp_mask = 4'h0;
         end
         if (start >= 0 && seen != 4'hF) begin
            if (edge_n - 1 - start >= S + 1) begin
               loss_apply = edge_n + 1;
               lost_seen  = seen;
               blocked_ok = edge_n + 2;
            end else begin
               exp_rst   = 4'hF;
               exp_ready = 1'b0;
            end
            start = -1;
         end else begin
            if (start < 0 && seen == 4'hF && edge_n >= blocked_ok) start = edge_n - 1;
            if (start >= 0) begin
               el = edge_n - start;
               for (int k = 0; k < N; k++) exp_rst[k] = (el < S + G + 1 + k * G);
               exp_ready = (el >= READY_EL);
            end else begin
               exp_rst   = 4'hF;
               exp_ready = 1'b0;
            end
         end
      end
      dq.push_back(locked_in);
      m_ls = dq.pop_front();
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("rst_out",   32'(rst_out),   32'(exp_rst));
      check("all_ready", 32'(all_ready), 32'(exp_ready));
      check("loss_cnt",  32'(loss_cnt),  32'(exp_cnt));
      check("loss_mask", 32'(loss_mask), 32'(exp_mask));
      check("pll_rst",   32'(pll_rst),   32'(0));
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_rst_out",   32'(rst_out),   32'hF);
      check("rst_all_ready", 32'(all_ready), 32'h0);
      check("rst_loss_cnt",  32'(loss_cnt),  32'h0);
      check("rst_loss_mask", 32'(loss_mask), 32'h0);
      check("rst_pll_rst",   32'(pll_rst),   32'h0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset     = 1'b1;
      clr       = 1'b0;
      locked_in = 4'hF;
      model_reset();

      // Power-up with all locks high
      do_reset(5);
      for (int n = 1; n <= 90; n++) begin
         tick();
         if (n == 14) check("pwr_rst_14", 32'(rst_out), 32'hF);
         if (n == 15) check("pwr_rst0_15", 32'(rst_out), 32'hE);
         if (n == 19) check("pwr_rst1_19", 32'(rst_out), 32'hC);
         if (n == 23) check("pwr_rst2_23", 32'(rst_out), 32'h8);
         if (n == 27) check("pwr_rst3_27", 32'(rst_out), 32'h0);
         if (n == 27) check("pwr_ready_27", 32'(all_ready), 32'h0);
         if (n == 28) check("pwr_ready_28", 32'(all_ready), 32'h1);
`ifdef CLK_LOCK_TIMEOUT_EN
         check("to_pll_rst", 32'(to_pll_rst),
               32'(((n >= 32) && (n <= 39)) || ((n >= 72) && (n <= 79))));
         check("to_rst_out", 32'(to_rst_out), 32'hF);
         check("to_ready",   32'(to_all_ready), 32'h0);
         check("to_cnt",     32'(to_loss_cnt), 32'h0);
         check("to_mask",    32'(to_loss_mask), 32'h0);
`endif
      end

      // Loss in RUN
      locked_in = 4'b1011;
      repeat (3) tick();
      check("run_hold_rst", 32'(rst_out), 32'h0);
      check("run_hold_ready", 32'(all_ready), 32'h1);
      tick();
      check("run_loss_rst", 32'(rst_out), 32'hF);
      check("run_loss_ready", 32'(all_ready), 32'h0);
      check("run_loss_cnt", 32'(loss_cnt), 32'h1);
      check("run_loss_mask", 32'(loss_mask), 32'h4);
      locked_in = 4'hF;
      repeat (40) tick();
      check("run_relock_ready", 32'(all_ready), 32'h1);

      // Asynchronous reset assertion between clock edges
      reset = 1'b1;
      #1;
      check("async_rst_out", 32'(rst_out), 32'hF);
      check("async_cnt", 32'(loss_cnt), 32'h0);

      // Bounce in STABLE restarts the release timing
      do_reset(3);
      repeat (5) tick();
      locked_in = 4'b1011;
      tick();
      locked_in = 4'hF;
      repeat (9) tick();
      check("bounce_rst_15", 32'(rst_out), 32'hF);
      repeat (5) tick();
      check("bounce_rst_20", 32'(rst_out), 32'hF);
      tick();
      check("bounce_rst_21", 32'(rst_out), 32'hE);
      check("bounce_cnt", 32'(loss_cnt), 32'h0);

      // Loss mid-RELEASE after bits 1:0 are released
      do_reset(3);
      repeat (20) tick();
      check("rel_rst_20", 32'(rst_out), 32'hC);
      locked_in = 4'b1110;
      repeat (3) tick();
      check("rel_rst_23", 32'(rst_out), 32'hC);
      tick();
      check("rel_rst_24", 32'(rst_out), 32'hF);
      check("rel_cnt_24", 32'(loss_cnt), 32'h1);
      check("rel_mask_24", 32'(loss_mask), 32'h1);
      locked_in = 4'hF;
      repeat (40) tick();

      // Saturation of the loss counter
      for (int i = 0; i < 260; i++) begin
         locked_in = 4'hF;
         repeat (14) tick();
         locked_in = 4'($urandom_range(0, 14));
         repeat (4) tick();
      end
      check("sat_cnt", 32'(loss_cnt), 32'd255);

      // CLR pulse
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_cnt", 32'(loss_cnt), 32'h0);
      check("clr_mask", 32'(loss_mask), 32'h0);

      // CLR coincident with a loss: the loss wins
      locked_in = 4'hF;
      repeat (30) tick();
      locked_in = 4'b0111;
      repeat (4) tick();
      check("pre_coinc_cnt", 32'(loss_cnt), 32'h1);
      locked_in = 4'hF;
      repeat (30) tick();
      locked_in = 4'b1110;
      repeat (3) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("coinc_cnt", 32'(loss_cnt), 32'h1);
      check("coinc_mask", 32'(loss_mask), 32'h1);
      locked_in = 4'hF;

      // Randomized lock activity and clr pulses
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            if ($urandom_range(0, 2) == 0) locked_in = 4'($urandom_range(0, 15));
            else                           locked_in = 4'hF;
         end
         clr = ($urandom_range(0, 30) == 0);
         tick();
      end
      clr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
